// File: rtl/bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the 128-bit memory bus.
// One slave transaction in flight at a time; the response is routed back to the granted master.
module bus_arbiter #(
    parameter int BUS_ADDRESS_WIDTH    = 20,
    parameter int BUS_DATA_WIDTH_SHIFT = 4,
    localparam int DW = 8 << BUS_DATA_WIDTH_SHIFT
) (
    input  logic                                            clk_i,
    input  logic                                            rst_i,
    input  logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] m0_addr_i,
    input  logic [DW-1:0]                                   m0_data_i,
    input  logic                                            m0_we_i,
    input  logic                                            m0_valid_i,
    output logic [DW-1:0]                                   m0_data_o,
    output logic                                            m0_valid_o,
    input  logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] m1_addr_i,
    input  logic [DW-1:0]                                   m1_data_i,
    input  logic                                            m1_we_i,
    input  logic                                            m1_valid_i,
    output logic [DW-1:0]                                   m1_data_o,
    output logic                                            m1_valid_o,
    output logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] s_addr_o,
    output logic [DW-1:0]                                   s_data_o,
    output logic                                            s_we_o,
    output logic                                            s_valid_o,
    input  logic [DW-1:0]                                   s_data_i,
    input  logic                                            s_valid_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic grant_q, grant_d;
    logic last_q, last_d;
    logic win_s;

    logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] s_addr_q, s_addr_d;
    logic [DW-1:0] s_data_q, s_data_d;
    logic          s_we_q, s_we_d;
    logic          s_valid_q, s_valid_d;
    logic [DW-1:0] m0_data_q, m0_data_d;
    logic [DW-1:0] m1_data_q, m1_data_d;
    logic          m0_valid_q, m0_valid_d;
    logic          m1_valid_q, m1_valid_d;

    // Round-robin pick: on a tie the master that was not served last wins.
    always_comb begin
        win_s = 1'b0;
        if (m0_valid_i && m1_valid_i) begin
            win_s = ~last_q;
        end else if (m1_valid_i) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m0_valid_i || m1_valid_i) begin
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (s_valid_i) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; master response pulses default low so they last one cycle.
    always_comb begin
        grant_d    = grant_q;
        last_d     = last_q;
        s_addr_d   = s_addr_q;
        s_data_d   = s_data_q;
        s_we_d     = s_we_q;
        s_valid_d  = s_valid_q;
        m0_data_d  = m0_data_q;
        m1_data_d  = m1_data_q;
        m0_valid_d = 1'b0;
        m1_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (m0_valid_i || m1_valid_i) begin
                    grant_d   = win_s;
                    s_addr_d  = win_s ? m1_addr_i : m0_addr_i;
                    s_data_d  = win_s ? m1_data_i : m0_data_i;
                    s_we_d    = win_s ? m1_we_i : m0_we_i;
                    s_valid_d = 1'b1;
                end else begin
                    s_valid_d = 1'b0;
                end
            end
            ST_BUSY: begin
                if (s_valid_i) begin
                    s_valid_d = 1'b0;
                    if (grant_q) begin
                        m1_data_d  = s_data_i;
                        m1_valid_d = 1'b1;
                    end else begin
                        m0_data_d  = s_data_i;
                        m0_valid_d = 1'b1;
                    end
                end else begin
                    s_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                last_d = grant_q;
            end
            default: begin
                s_valid_d = 1'b0;
            end
        endcase
    end

    // Registered outputs and arbitration bookkeeping; last resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            s_addr_q   <= '0;
            s_data_q   <= '0;
            s_we_q     <= 1'b0;
            s_valid_q  <= 1'b0;
            m0_data_q  <= '0;
            m1_data_q  <= '0;
            m0_valid_q <= 1'b0;
            m1_valid_q <= 1'b0;
        end else begin
            grant_q    <= grant_d;
            last_q     <= last_d;
            s_addr_q   <= s_addr_d;
            s_data_q   <= s_data_d;
            s_we_q     <= s_we_d;
            s_valid_q  <= s_valid_d;
            m0_data_q  <= m0_data_d;
            m1_data_q  <= m1_data_d;
            m0_valid_q <= m0_valid_d;
            m1_valid_q <= m1_valid_d;
        end
    end

    assign s_addr_o   = s_addr_q;
    assign s_data_o   = s_data_q;
    assign s_we_o     = s_we_q;
    assign s_valid_o  = s_valid_q;
    assign m0_data_o  = m0_data_q;
    assign m1_data_o  = m1_data_q;
    assign m0_valid_o = m0_valid_q;
    assign m1_valid_o = m1_valid_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, corner-case sequences and
// randomized traffic checked against a transaction-level reference model with a behavioural RAM.
module tb_bus_arbiter;

    localparam int AW = 20;
    localparam int SH = 4;
    localparam int DW = 128;

    localparam logic [DW-1:0] L10  = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [DW-1:0] L40  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [DW-1:0] A5   = {16{8'hA5}};
    localparam logic [DW-1:0] C3   = {16{8'h3C}};
    localparam logic [DW-1:0] S77  = {16{8'h77}};
    localparam logic [DW-1:0] ZERO = {DW{1'b0}};

    logic clk_i = 1'b0;
    logic rst_i;
    logic [AW-1:SH] m0_addr_i, m1_addr_i, s_addr_o;
    logic [DW-1:0]  m0_data_i, m1_data_i, m0_data_o, m1_data_o, s_data_o, s_data_i;
    logic           m0_we_i, m1_we_i, m0_valid_i, m1_valid_i;
    logic           m0_valid_o, m1_valid_o, s_we_o, s_valid_o, s_valid_i;

    always #5 clk_i = ~clk_i;

    bus_arbiter #(.BUS_ADDRESS_WIDTH(AW), .BUS_DATA_WIDTH_SHIFT(SH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_we_i(m0_we_i), .m0_valid_i(m0_valid_i),
        .m0_data_o(m0_data_o), .m0_valid_o(m0_valid_o),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_we_i(m1_we_i), .m1_valid_i(m1_valid_i),
        .m1_data_o(m1_data_o), .m1_valid_o(m1_valid_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_valid_o(s_valid_o),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i)
    );

    typedef struct {
        logic        v0;
        logic        we0;
        logic [15:0] a0;
        logic [DW-1:0] d0;
        logic        v1;
        logic        we1;
        logic [15:0] a1;
        logic [DW-1:0] d1;
        logic        first;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } row_t;

    int n_chk = 0;
    int n_fail = 0;

    logic [DW-1:0] slave_mem [int];
    logic [DW-1:0] ref_mem [int];
    logic          slave_auto;
    logic          stray;
    int            lat;
    int            scnt;

    logic          last_srv, pend_g, in_flight, prev_sv;
    logic [1:0]    prev_mv, req_snap;
    logic [DW-1:0] exp_rsp;
    logic          served_q [$];
    logic [DW-1:0] rsp_data [2];
    int            rsp_cnt [2];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : ZERO;
    endfunction

    task automatic set_req(input logic m, input logic we, input logic [15:0] a, input logic [DW-1:0] d);
        if (m) begin
            m1_we_i = we; m1_addr_i = a; m1_data_i = d; m1_valid_i = 1'b1;
        end else begin
            m0_we_i = we; m0_addr_i = a; m0_data_i = d; m0_valid_i = 1'b1;
        end
    endtask

    // One clock: monitor / reference model, master response handling, then the slave RAM model.
    task automatic tick();
        logic g;
        logic got;
        int   a;
        req_snap = {m1_valid_i, m0_valid_i};
        @(negedge clk_i);
        if (rst_i) begin
            if (s_valid_o && !prev_sv) begin
                g = (req_snap == 2'b11) ? ~last_srv : (req_snap == 2'b10);
                check("issue_has_request", DW'(req_snap != 2'b00), DW'(1'b1));
                check("issue_addr", DW'(s_addr_o), DW'(g ? m1_addr_i : m0_addr_i));
                check("issue_we", DW'(s_we_o), DW'(g ? m1_we_i : m0_we_i));
                check("issue_data", s_data_o, g ? m1_data_i : m0_data_i);
                a = int'(g ? m1_addr_i : m0_addr_i);
                if (g ? m1_we_i : m0_we_i) begin
                    exp_rsp = g ? m1_data_i : m0_data_i;
                    ref_mem[a] = exp_rsp;
                end else begin
                    exp_rsp = ref_rd(a);
                end
                pend_g = g;
                in_flight = 1'b1;
            end
            if (m0_valid_o || m1_valid_o) begin
                got = m1_valid_o;
                check("one_hot_valid_o", DW'(m0_valid_o & m1_valid_o), DW'(1'b0));
                check("response_in_flight", DW'(in_flight), DW'(1'b1));
                check("response_master", DW'(got), DW'(pend_g));
                check("response_pulse_width", DW'(prev_mv), DW'(2'b00));
                check("s_valid_falls", DW'(s_valid_o), DW'(1'b0));
                check("response_data", got ? m1_data_o : m0_data_o, exp_rsp);
                in_flight = 1'b0;
                last_srv = got;
                served_q.push_back(got);
                rsp_data[got] = got ? m1_data_o : m0_data_o;
                rsp_cnt[got]++;
                if (got) m1_valid_i = 1'b0;
                else     m0_valid_i = 1'b0;
            end
        end
        prev_sv = s_valid_o;
        prev_mv = {m1_valid_o, m0_valid_o};
        if (s_valid_i) begin
            s_valid_i = 1'b0;
        end else if (stray) begin
            s_valid_i = 1'b1;
            s_data_i = {4{32'hDEADBEEF}};
            stray = 1'b0;
        end else if (!rst_i || !slave_auto || !s_valid_o) begin
            scnt = 0;
        end else begin
            scnt++;
            if (scnt >= lat) begin
                scnt = 0;
                a = int'(s_addr_o);
                if (s_we_o) begin
                    slave_mem[a] = s_data_o;
                    s_data_i = s_data_o;
                end else begin
                    s_data_i = slave_mem.exists(a) ? slave_mem[a] : ZERO;
                end
                s_valid_i = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        last_srv = 1'b1;
        in_flight = 1'b0;
        prev_sv = 1'b0;
        prev_mv = 2'b00;
        served_q.delete();
        rsp_cnt[0] = 0;
        rsp_cnt[1] = 0;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        m0_valid_i = 1'b0;
        m1_valid_i = 1'b0;
        s_valid_i = 1'b0;
        stray = 1'b0;
        slave_auto = 1'b1;
        tick();
        tick();
        rst_i = 1'b1;
        model_reset();
    endtask

    task automatic wait_all(input int budget);
        int b = 0;
        while ((m0_valid_i || m1_valid_i || in_flight) && b < budget) begin
            tick();
            b++;
        end
        if (b >= budget) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_timeout: got outstanding requests after %0d cycles expected none", budget);
            m0_valid_i = 1'b0;
            m1_valid_i = 1'b0;
        end
    endtask

    task automatic run_row(input row_t r);
        served_q.delete();
        if (r.v0) set_req(1'b0, r.we0, r.a0, r.d0);
        if (r.v1) set_req(1'b1, r.we1, r.a1, r.d1);
        wait_all(200);
        check("row_count", DW'(served_q.size()), DW'(int'(r.v0) + int'(r.v1)));
        if (served_q.size() > 0) check("row_first", DW'(served_q[0]), DW'(r.first));
        if (r.v0) check("row_m0_data", rsp_data[0], r.e0);
        if (r.v1) check("row_m1_data", rsp_data[1], r.e1);
    endtask

    initial begin
        row_t rows [8];
        int   issued;
        int   b;

        rst_i = 1'b0;
        m0_addr_i = '0; m1_addr_i = '0; m0_data_i = ZERO; m1_data_i = ZERO;
        m0_we_i = 1'b0; m1_we_i = 1'b0; m0_valid_i = 1'b0; m1_valid_i = 1'b0;
        s_data_i = ZERO; s_valid_i = 1'b0; stray = 1'b0; slave_auto = 1'b1;
        lat = 3; scnt = 0;
        rsp_data[0] = ZERO; rsp_data[1] = ZERO;
        slave_mem[16'h0010] = L10; ref_mem[16'h0010] = L10;
        slave_mem[16'h0040] = L40; ref_mem[16'h0040] = L40;
        model_reset();

        rows[0] = '{1'b1, 1'b0, 16'h0010, ZERO, 1'b1, 1'b1, 16'h0020, A5,   1'b0, L10, A5};
        rows[1] = '{1'b1, 1'b0, 16'h0040, ZERO, 1'b0, 1'b0, 16'h0000, ZERO, 1'b0, L40, ZERO};
        rows[2] = '{1'b0, 1'b0, 16'h0000, ZERO, 1'b1, 1'b0, 16'h0020, ZERO, 1'b1, ZERO, A5};
        rows[3] = '{1'b1, 1'b1, 16'h0030, C3,   1'b1, 1'b0, 16'h0040, ZERO, 1'b0, C3, L40};
        rows[4] = '{1'b1, 1'b0, 16'h0030, ZERO, 1'b0, 1'b0, 16'h0000, ZERO, 1'b0, C3, ZERO};
        rows[5] = '{1'b1, 1'b0, 16'h0020, ZERO, 1'b1, 1'b0, 16'h0030, ZERO, 1'b1, A5, C3};
        rows[6] = '{1'b1, 1'b1, 16'h0040, S77,  1'b1, 1'b0, 16'h0010, ZERO, 1'b1, S77, L10};
        rows[7] = '{1'b0, 1'b0, 16'h0000, ZERO, 1'b1, 1'b0, 16'h0040, ZERO, 1'b1, ZERO, S77};

        // Reset state, then a single latency-3 read from master 0.
        rst_i = 1'b0;
        #1;
        check("reset_outputs_zero", DW'(|{s_addr_o, s_data_o, s_we_o, s_valid_o, m0_data_o,
              m0_valid_o, m1_data_o, m1_valid_o}), DW'(1'b0));
        do_reset();
        lat = 3;
        set_req(1'b0, 1'b0, 16'h0040, ZERO);
        for (int t = 1; t <= 4; t++) begin
            tick();
            if (t == 1) check("single_s_valid_cycle1", DW'(s_valid_o), DW'(1'b1));
            check("single_rsp_timing", DW'(rsp_cnt[0]), DW'((t == 4) ? 1 : 0));
        end
        check("single_rsp_data", rsp_data[0], L40);
        wait_all(50);
        tick();
        check("single_no_m1_rsp", DW'(rsp_cnt[1]), DW'(0));

        // Directed vector table from reset.
        do_reset();
        lat = 2;
        for (int i = 0; i < 8; i++) run_row(rows[i]);

        // Round-robin fairness with both masters requesting continuously.
        do_reset();
        lat = 2;
        set_req(1'b0, 1'b0, 16'(($urandom % 8)), ZERO);
        set_req(1'b1, 1'b0, 16'(($urandom % 8)), ZERO);
        issued = 2;
        b = 0;
        while (served_q.size() < 8 && b < 400) begin
            tick();
            b++;
            if (!m0_valid_i && issued < 8) begin
                set_req(1'b0, 1'($urandom % 2), 16'(($urandom % 8)), {$urandom, $urandom, $urandom, $urandom});
                issued++;
            end
            if (!m1_valid_i && issued < 8) begin
                set_req(1'b1, 1'($urandom % 2), 16'(($urandom % 8)), {$urandom, $urandom, $urandom, $urandom});
                issued++;
            end
        end
        check("fair_total", DW'(served_q.size()), DW'(8));
        for (int i = 0; i < 8 && i < served_q.size(); i++) check("fair_order", DW'(served_q[i]), DW'(i % 2));
        check("fair_m0_count", DW'(rsp_cnt[0]), DW'(4));
        check("fair_m1_count", DW'(rsp_cnt[1]), DW'(4));
        wait_all(100);

        // Master 1 arrives while master 0 is busy and stays pending.
        do_reset();
        lat = 3;
        set_req(1'b0, 1'b0, 16'h0040, ZERO);
        tick();
        tick();
        set_req(1'b1, 1'b1, 16'h0055, A5);
        wait_all(100);
        check("pending_count", DW'(served_q.size()), DW'(2));
        if (served_q.size() == 2) check("pending_second", DW'(served_q[1]), DW'(1'b1));

        // Asynchronous reset while busy, stray slave pulses during and after reset.
        do_reset();
        slave_auto = 1'b0;
        set_req(1'b0, 1'b0, 16'h0010, ZERO);
        tick();
        check("midrst_busy", DW'(s_valid_o), DW'(1'b1));
        tick();
        #2 rst_i = 1'b0;
        #1;
        check("midrst_async_zero", DW'(|{s_addr_o, s_data_o, s_we_o, s_valid_o, m0_data_o,
              m0_valid_o, m1_data_o, m1_valid_o}), DW'(1'b0));
        m0_valid_i = 1'b0;
        stray = 1'b1;
        tick();
        tick();
        rst_i = 1'b1;
        model_reset();
        stray = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            check("stray_no_activity", DW'({m1_valid_o, m0_valid_o, s_valid_o}), DW'(3'b000));
        end
        check("stray_no_response", DW'(rsp_cnt[0] + rsp_cnt[1]), DW'(0));
        slave_auto = 1'b1;
        lat = 1;
        set_req(1'b0, 1'b0, 16'h0040, ZERO);
        set_req(1'b1, 1'b0, 16'h0010, ZERO);
        wait_all(100);
        check("postrst_tie_m0_first", DW'(served_q.size() > 0 ? served_q[0] : 1'b1), DW'(1'b0));

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            lat = $urandom_range(1, 4);
            if (!m0_valid_i && $urandom_range(0, 2) == 0)
                set_req(1'b0, 1'($urandom % 2), 16'(($urandom % 8)), {$urandom, $urandom, $urandom, $urandom});
            if (!m1_valid_i && $urandom_range(0, 2) == 0)
                set_req(1'b1, 1'($urandom % 2), 16'(($urandom % 8)), {$urandom, $urandom, $urandom, $urandom});
            tick();
        end
        wait_all(100);
        check("random_some_traffic", DW'(rsp_cnt[0] > 10 && rsp_cnt[1] > 10), DW'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter for the 128-bit memory bus. Instruction-side and data-side requesters inside the CPU share the single port of `slow_ram` through it. One transaction is in flight at a time; masters are granted round-robin, and the slave's response is routed back to the granted master. The slave side uses the same address/data/we/valid protocol that `slow_ram` already accepts.

## Interface
- `BUS_ADDRESS_WIDTH`, default 20: byte-address width.
- `BUS_DATA_WIDTH_SHIFT`, default 4: log2 of the line size in bytes. Data width is DW = 8·2^shift = 128.
- `clk_i` input, 1: single clock, rising edge.
- `rst_i` input, 1: asynchronous, active-low reset.
- `m0_addr_i` input, [AW-1:shift]: master 0 (instruction side) line address.
- `m0_data_i` input, DW: master 0 write data.
- `m0_we_i` input, 1: master 0 write enable.
- `m0_valid_i` input, 1: master 0 request.
- `m0_data_o` output, DW: master 0 response data.
- `m0_valid_o` output, 1: master 0 response pulse.
- `m1_*`: same six ports for master 1 (data side).
- `s_addr_o` output, [AW-1:shift]: address to the slave.
- `s_data_o` output, DW: write data to the slave.
- `s_we_o` output, 1: write enable to the slave.
- `s_valid_o` output, 1: request to the slave.
- `s_data_i` input, DW: slave read data.
- `s_valid_i` input, 1: slave response/ack pulse.

## Operation
- **Master protocol.**
  - A master raises `mX_valid_i` with addr/data/we stable and holds them until it sees `mX_valid_o`=1.
  - It drops or changes the request on the following edge.
- **Slave protocol.**
  - `s_valid_o` and the request fields are held until `s_valid_i`=1 is sampled.
  - The slave pulses `s_valid_i` for one cycle, for reads and writes alike.
- **FSM states:** IDLE, BUSY, DONE.
  - **IDLE.** If any `mX_valid_i` is high, select a winner, register its addr/data/we into `s_*_o`, set `s_valid_o`=1, latch `grant`, and go to BUSY. Otherwise stay in IDLE.
  - **BUSY.** On `s_valid_i`=1, capture `s_data_i` into `m{grant}_data_o`, set `m{grant}_valid_o`=1, clear `s_valid_o`, and go to DONE.
  - **DONE.** Lasts one cycle: clear `mX_valid_o` and go to IDLE. Update the round-robin pointer `last` to `grant`.
- **Arbitration.**
  - Single requester: it wins.
  - Both requesting: the master ≠ `last` wins.
  - `last` resets to 1, so master 0 wins the first tie.
- The non-granted master's request is left pending. It is never dropped and is evaluated again at the next IDLE.
- Write transactions still forward `s_data_i` to `mX_data_o`, and masters ignore it. `m_data_o` holds its value between responses.
- `s_valid_i` is ignored outside BUSY.
- A request deasserted by a master while BUSY does not abort the slave transaction. The response is still delivered.

## Timing
- **Reset values.** All outputs are 0; state is IDLE; `grant`=0; `last`=1. Assertion is asynchronous and clears any in-flight transaction, which is lost. Masters reissue after reset.
- **Latency.**
  - Request sampled in IDLE at cycle 0 → `s_valid_o`=1 from cycle 1.
  - Slave responds at cycle k → `mX_valid_o`=1 at cycle k+1 only.
  - IDLE at cycle k+2, which is the earliest cycle a next request is sampled.
- Back-to-back overhead: 3 cycles per transaction plus slave latency.
- `mX_valid_o` is exactly one cycle wide, and at most one `mX_valid_o` is high at a time.
- `s_valid_o` falls on the same edge `mX_valid_o` rises.
- Release from reset takes effect synchronously: the first sample is on the first rising edge with `rst_i`=1.

## Test plan
- **Single read.** With a latency-3 RAM model preloaded with 0x00112233…FF at line 0x0040: m0 read of 0x0040 → `s_valid_o` high at cycle 1 → `m0_valid_o` one-cycle pulse with that data; `m1_valid_o` stays 0.
- **Simultaneous requests from reset.** m0 reads 0x0010 while m1 writes 0xA5A5…A5 to 0x0020 → m0 is served first and m1 second, with no cycle lost beyond the 3-cycle overhead. A later read of 0x0020 returns 0xA5A5…A5.
- **Round-robin fairness.** Both masters request continuously for 8 transactions → grants alternate 0,1,0,1,… ; each master receives exactly 4 `valid_o` pulses.
- **Pending hold.** m1 requests during m0's BUSY phase → m1's request is issued to the slave at the IDLE after m0's DONE, with addr/we unchanged.
- **Reset mid-operation.** `rst_i`=0 asserted while BUSY → all outputs 0 immediately (asynchronous), no `mX_valid_o` is produced, and a late `s_valid_i` pulse is ignored. After release, m0 wins the first tie.
- **Stray slave pulse.** `s_valid_i` pulsed while IDLE → no `mX_valid_o` and no state change.
